// File: rtl/paper_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// paper_ctrl_fsm
//   Multi-cycle control sequencer for the PaperProcessor datapath. It steps
//   one instruction at a time through FETCH, DECODE, EXEC, MEM and WB, using
//   the opcode held in IR and the ALU zero flag. It drives the load enables of
//   the PC, IR and register file and runs the handshake to the shared
//   instruction/data memory port.
//
// Parameters
//   CNTW    width of the retired-instruction counter instr_cnt
//   MEM_TO  number of unacknowledged request cycles before a memory timeout
//           (must be at least 2)
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   r          in   asynchronous active-high reset
//   run        in   level, leaves HALT when high (ignored elsewhere)
//   ir_op      in   opcode field of the current IR
//   zero       in   ALU zero flag, meaningful in EXEC
//   mem_ack    in   memory completes the current request this cycle
//   mem_req    out  memory request, held until ack or timeout
//   mem_we     out  request is a write (store), 0 means read
//   pc_en      out  PC load enable, single-cycle pulse
//   pc_sel     out  PC source: 0 PC+1, 1 branch target, 2 jump target
//   ir_en      out  IR load enable, single-cycle pulse
//   alu_en     out  ALU result register enable
//   rf_we      out  register file write enable, single-cycle pulse
//   rf_src     out  write-back source: 0 ALU, 1 memory data
//   halted     out  FSM is in HALT
//   illegal    out  single-cycle pulse, undefined opcode decoded
//   err        out  sticky memory timeout flag, cleared when leaving HALT
//   state      out  current state encoding (debug)
//   instr_cnt  out  count of instructions leaving DECODE, wraps
// ---------------------------------------------------------------------------
module paper_ctrl_fsm #(
  parameter int CNTW   = 8,
  parameter int MEM_TO = 16
) (
  input  logic            clk,
  input  logic            r,
  input  logic            run,
  input  logic [3:0]      ir_op,
  input  logic            zero,
  input  logic            mem_ack,
  output logic            mem_req,
  output logic            mem_we,
  output logic            pc_en,
  output logic [1:0]      pc_sel,
  output logic            ir_en,
  output logic            alu_en,
  output logic            rf_we,
  output logic            rf_src,
  output logic            halted,
  output logic            illegal,
  output logic            err,
  output logic [2:0]      state,
  output logic [CNTW-1:0] instr_cnt
);

  // State encoding is visible on the debug port, so the values are fixed.
  typedef enum logic [2:0] {
    S_HALT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ALU   = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_STORE = 4'd3;
  localparam logic [3:0] OP_BEQ   = 4'd4;
  localparam logic [3:0] OP_JMP   = 4'd5;
  localparam logic [3:0] OP_HALT  = 4'd15;

  localparam int WW = (MEM_TO > 2) ? $clog2(MEM_TO) : 1;

  // Value of the wait counter in the last request cycle that may still be
  // acknowledged; no ack in that cycle means timeout.
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TO - 1);

  localparam logic [1:0] PC_INC    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  state_t          state_q, state_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            err_q, err_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic            mem_timeout;

  // A request cycle without ack while the counter sits on its last value
  // aborts the instruction. Only meaningful in FETCH and MEM.
  assign mem_timeout = !mem_ack && (wait_q == WAIT_LAST);

  // State register. Reset is asynchronous so the strobes (all decoded from
  // state_q) drop the moment r rises, abandoning any in-flight request.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q <= S_HALT;
      wait_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. ir_op is read directly in EXEC, MEM and WB because IR
  // is only reloaded by the FETCH ack, so the opcode is stable until then.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_HALT: begin
        if (run) begin
          state_d = S_FETCH;
          err_d   = 1'b0;
        end
      end

      S_FETCH: begin
        if (mem_ack) begin
          state_d = S_DECODE;
        end else if (mem_timeout) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      S_DECODE: begin
        // Every instruction leaving DECODE is counted, including HALT and
        // undefined opcodes.
        cnt_d = cnt_q + CNTW'(1);
        case (ir_op)
          OP_HALT:  state_d = S_HALT;
          OP_ALU,
          OP_LOAD,
          OP_STORE,
          OP_BEQ,
          OP_JMP:   state_d = S_EXEC;
          default:  state_d = S_FETCH;
        endcase
      end

      S_EXEC: begin
        case (ir_op)
          OP_ALU:   state_d = S_WB;
          OP_LOAD,
          OP_STORE: state_d = S_MEM;
          default:  state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        if (mem_ack) begin
          state_d = (ir_op == OP_LOAD) ? S_WB : S_FETCH;
        end else if (mem_timeout) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      S_WB: begin
        state_d = S_FETCH;
      end

      default: begin
        state_d = S_HALT;
      end
    endcase

    // The wait counter restarts on every fresh entry to a request state.
    if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) begin
      wait_d = '0;
    end
  end

  // Output decode. The FETCH enables are combinational on mem_ack so IR and
  // PC load on the same edge that the memory delivers the instruction.
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    pc_en   = 1'b0;
    pc_sel  = PC_INC;
    ir_en   = 1'b0;
    alu_en  = 1'b0;
    rf_we   = 1'b0;
    rf_src  = 1'b0;
    illegal = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_en = 1'b1;
          pc_en = 1'b1;
        end
      end

      S_DECODE: begin
        case (ir_op)
          OP_NOP, OP_ALU, OP_LOAD, OP_STORE,
          OP_BEQ, OP_JMP, OP_HALT: illegal = 1'b0;
          default:                 illegal = 1'b1;
        endcase
      end

      S_EXEC: begin
        alu_en = 1'b1;
        if (ir_op == OP_BEQ) begin
          pc_en  = zero;
          pc_sel = PC_BRANCH;
        end else if (ir_op == OP_JMP) begin
          pc_en  = 1'b1;
          pc_sel = PC_JUMP;
        end
      end

      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (ir_op == OP_STORE);
      end

      S_WB: begin
        rf_we  = 1'b1;
        rf_src = (ir_op == OP_LOAD);
      end

      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  assign halted    = (state_q == S_HALT);
  assign err       = err_q;
  assign state     = state_q;
  assign instr_cnt = cnt_q;

endmodule
